instr_loader: RTL and testbench
===============================

Name: instr_loader

Overview:
Sequential instruction encoder/loader for the KGPRISC single-cycle CPU. It accepts decoded instruction fields over a valid/ready handshake and packs them into 32-bit KGPRISC words. It writes the words into instruction memory at consecutive addresses. When loading completes it raises cpu_start, the start qualifier consumed by the instruction decoder. It is the writer/encoder end of the instruction-word interface that the decoder reads.

Parameters:
ADDR_W, 8, instruction-memory word-address width
DEPTH, 256, maximum words per load session (must be <= 2**ADDR_W)
BASE_ADDR, 0, first word address written in each session

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
load_start  in  1  pulse: open a new load session
load_done  in  1  pulse: close the session, release CPU
in_valid  in  1  instruction fields valid
in_ready  out  1  loader can accept fields this cycle
op  in  6  opcode, placed at [31:26]
rs  in  5  placed at [25:21] (R, I, br formats)
rt  in  5  placed at [20:16] (R, I formats)
shamt  in  5  placed at [10:6] (R format)
func  in  6  placed at [5:0] (R format)
imm16  in  16  placed at [15:0] (I format)
addr26  in  26  placed at [25:0] (jump format)
imem_we  out  1  instruction-memory write strobe
imem_addr  out  ADDR_W  write address
imem_wdata  out  32  encoded instruction word
cpu_start  out  1  CPU run enable
count  out  ADDR_W+1  words written this session
full  out  1  count == DEPTH
err  out  1  sticky illegal-opcode flag

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs are 0: in_ready, imem_we, imem_addr, imem_wdata, cpu_start, count, full, err. The pending-done flag is also cleared.
- Formats: every field not used by the format is 0.
  - R, op 000000: rs, rt, shamt, func.
  - I, ops 000100 addi, 000101 compi, 000010 lw, 000011 sw: rs, rt, imm16.
  - br, op 010001: rs only.
  - Jump, ops 010000 and 010010–011001 plus 000110 call: addr26.
  - ret, op 000111: opcode only.
  - Any other opcode is illegal.
- States:
  - IDLE: in_ready=0. load_start -> LOAD.
  - LOAD: in_ready=1 when !full. A handshake (in_valid & in_ready) registers the encoded word and the legal flag -> WRITE.
  - WRITE: in_ready=0. A legal word drives imem_we=1 for exactly this cycle, with imem_addr=BASE_ADDR+count and imem_wdata=word; count increments at the end of the cycle. An illegal word gives no write, count unchanged, err<=1. Then -> LOAD, or -> RUN if the pending-done flag is set.
  - RUN: cpu_start=1, in_ready=0. load_start -> LOAD; cpu_start drops the next cycle.
- Latency: handshake at cycle N gives the write strobe at cycle N+1. Throughput is one word per 2 cycles.
- load_done:
  - In LOAD with no handshake: -> RUN next cycle.
  - Coincident with a handshake, or arriving during WRITE: latched as pending; RUN is entered after the write.
  - Ignored in IDLE and RUN.
- load_start:
  - In any state, aborts the session: pending write dropped, count=0, err=0, pending-done cleared, cpu_start=0, -> LOAD.
  - Has priority over load_done and the handshake in the same cycle.
- Full: once count==DEPTH, full=1 and in_ready stays 0. load_done still moves to RUN. imem_addr never exceeds BASE_ADDR+DEPTH-1.
- imem_addr/imem_wdata are held between writes. They are meaningful only when imem_we=1.

Decomposition:
- Package kgprisc_isa_pkg:
  - 6-bit opcode constants (R, ADDI, COMPI, LW, SW, B, BR, BZ..BNV, CALL, RET).
  - Format enum {FMT_R, FMT_I, FMT_BR, FMT_J, FMT_RET, FMT_ILL}.
  - Field bit-position constants.
  - The package is shared with the decoder.
- Sub-module instr_encoder: purely combinational; op plus fields -> {word[31:0], legal}. The loader holds only the FSM, counter and registers.

Test Plan:
- load_start, then addi op=000100 rs=3 rt=5 imm16=0x0010, then load_done -> one imem_we pulse, addr 0, wdata 0x10650010; count=1; cpu_start=1 two cycles after the write.
- R-type op=000000 rs=1 rt=2 shamt=0 func=0x01, then b op=010000 addr26=0x40, then ret op=000111 -> writes 0x00220001 @0, 0x40000040 @1, 0x1C000000 @2; stray imm16/addr26 values are ignored.
- Illegal op=111111 between two legal words -> no strobe for it, err=1 sticky; the legal words land at addr 0 and 1.
- DEPTH=4 build: issue 5 instructions -> 4 writes, full=1, in_ready=0; load_done -> cpu_start=1.
- load_done in the same cycle as a handshake -> that word is written, then RUN; a load_start in RUN clears cpu_start, count and err the next cycle.
- rst_n low during WRITE -> imem_we never pulses, all outputs 0 asynchronously.

Source files
------------

// File: rtl/kgprisc_isa_pkg.sv
// KGPRISC instruction-set constants shared by the loader/encoder and the decoder.
// Opcode values, instruction formats and field bit positions of the 32-bit word.
package kgprisc_isa_pkg;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b000010;
  localparam logic [5:0] OP_SW    = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b000100;
  localparam logic [5:0] OP_COMPI = 6'b000101;
  localparam logic [5:0] OP_CALL  = 6'b000110;
  localparam logic [5:0] OP_RET   = 6'b000111;
  localparam logic [5:0] OP_B     = 6'b010000;
  localparam logic [5:0] OP_BR    = 6'b010001;
  localparam logic [5:0] OP_BZ    = 6'b010010;
  localparam logic [5:0] OP_BNZ   = 6'b010011;
  localparam logic [5:0] OP_BCY   = 6'b010100;
  localparam logic [5:0] OP_BNCY  = 6'b010101;
  localparam logic [5:0] OP_BS    = 6'b010110;
  localparam logic [5:0] OP_BNS   = 6'b010111;
  localparam logic [5:0] OP_BV    = 6'b011000;
  localparam logic [5:0] OP_BNV   = 6'b011001;

  localparam int OP_LSB    = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int SHAMT_LSB = 6;
  localparam int FUNC_LSB  = 0;
  localparam int IMM_LSB   = 0;
  localparam int ADDR_LSB  = 0;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_BR, FMT_J, FMT_RET, FMT_ILL} fmt_e;

  function automatic fmt_e op_format(input logic [5:0] op);
    fmt_e f;
    case (op)
      OP_R:                                  f = FMT_R;
      OP_ADDI, OP_COMPI, OP_LW, OP_SW:       f = FMT_I;
      OP_BR:                                 f = FMT_BR;
      OP_B, OP_BZ, OP_BNZ, OP_BCY, OP_BNCY,
      OP_BS, OP_BNS, OP_BV, OP_BNV, OP_CALL: f = FMT_J;
      OP_RET:                                f = FMT_RET;
      default:                               f = FMT_ILL;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/instr_encoder.sv
// Combinational packer: opcode plus decoded fields -> 32-bit KGPRISC word and legal flag.
// Fields the format does not use stay zero; an illegal opcode yields word 0, legal 0.
module instr_encoder
  import kgprisc_isa_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  shamt_i,
  input  logic [5:0]  func_i,
  input  logic [15:0] imm16_i,
  input  logic [25:0] addr26_i,
  output logic [31:0] word_o,
  output logic        legal_o
);

  fmt_e fmt;

  always_comb begin
    fmt     = op_format(op_i);
    word_o  = 32'(op_i) << OP_LSB;
    legal_o = 1'b1;
    case (fmt)
      FMT_R:   word_o = word_o | (32'(rs_i) << RS_LSB) | (32'(rt_i) << RT_LSB)
                               | (32'(shamt_i) << SHAMT_LSB) | (32'(func_i) << FUNC_LSB);
      FMT_I:   word_o = word_o | (32'(rs_i) << RS_LSB) | (32'(rt_i) << RT_LSB)
                               | (32'(imm16_i) << IMM_LSB);
      FMT_BR:  word_o = word_o | (32'(rs_i) << RS_LSB);
      FMT_J:   word_o = word_o | (32'(addr26_i) << ADDR_LSB);
      FMT_RET: word_o = word_o;
      default: begin
        word_o  = '0;
        legal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_loader.sv
// Session loader: encodes accepted fields and writes them to consecutive imem words, then raises cpu_start.
// Write strobe one cycle after the handshake; in_ready low outside LOAD and when full (one word per 2 cycles).
module instr_loader
  import kgprisc_isa_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        op,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        shamt,
  input  logic [5:0]        func,
  input  logic [15:0]       imm16,
  input  logic [25:0]       addr26,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_start,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_RUN} state_e;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

  state_e              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                err_q, err_d;
  logic                done_pend_q, done_pend_d;
  logic                legal_q, legal_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         enc_word;
  logic                enc_legal;
  logic                hs;

  instr_encoder u_enc (
    .op_i     (op),
    .rs_i     (rs),
    .rt_i     (rt),
    .shamt_i  (shamt),
    .func_i   (func),
    .imm16_i  (imm16),
    .addr26_i (addr26),
    .word_o   (enc_word),
    .legal_o  (enc_legal)
  );

  assign full       = (count_q == DEPTH_C);
  assign in_ready   = (state_q == S_LOAD) && !full;
  assign hs         = in_valid && in_ready;
  // An abort arriving in WRITE suppresses the strobe for the dropped word.
  assign imem_we    = (state_q == S_WRITE) && legal_q && !load_start;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_start  = (state_q == S_RUN);
  assign count      = count_q;
  assign err        = err_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    err_d       = err_q;
    done_pend_d = done_pend_q;
    legal_d     = legal_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if (load_start) begin
      state_d     = S_LOAD;
      count_d     = '0;
      err_d       = 1'b0;
      done_pend_d = 1'b0;
      legal_d     = 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (hs) begin
            state_d     = S_WRITE;
            legal_d     = enc_legal;
            done_pend_d = load_done;
            if (enc_legal) begin
              addr_d  = BASE_C + count_q[ADDR_W-1:0];
              wdata_d = enc_word;
            end
          end else if (load_done) begin
            state_d = S_RUN;
          end
        end
        S_WRITE: begin
          if (legal_q) count_d = count_q + 1'b1;
          else         err_d   = 1'b1;
          done_pend_d = 1'b0;
          state_d     = (done_pend_q || load_done) ? S_RUN : S_LOAD;
        end
        S_IDLE, S_RUN: state_d = state_q;
        default:       state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      err_q       <= 1'b0;
      done_pend_q <= 1'b0;
      legal_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      err_q       <= err_d;
      done_pend_q <= done_pend_d;
      legal_q     <= legal_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader built with DEPTH=4: encoding table plus session/flow sequences.
module tb_instr_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load_start, load_done, in_valid;
  logic              in_ready;
  logic [5:0]        op;
  logic [4:0]        rs, rt, shamt;
  logic [5:0]        func;
  logic [15:0]       imm16;
  logic [25:0]       addr26;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_start;
  logic [ADDR_W:0]   count;
  logic              full, err;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;

  instr_loader #(.ADDR_W(ADDR_W), .DEPTH(4), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_done(load_done),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .rs(rs), .rt(rt),
    .shamt(shamt), .func(func), .imm16(imm16), .addr26(addr26),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_start(cpu_start), .count(count), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (imem_we) we_cnt++;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [25:0] a26;
    logic [31:0] word;
    logic        legal;
  } vec_t;

  function automatic vec_t mk(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t,
                              input logic [4:0] h, input logic [5:0] f, input logic [15:0] i,
                              input logic [25:0] a, input logic [31:0] w, input logic l);
    vec_t v;
    v.op = o; v.rs = s; v.rt = t; v.sh = h; v.fn = f; v.imm = i; v.a26 = a; v.word = w; v.legal = l;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    op = v.op; rs = v.rs; rt = v.rt; shamt = v.sh; func = v.fn; imm16 = v.imm; addr26 = v.a26;
  endtask

  task automatic session;
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
  endtask

  // Waits (bounded) for in_ready, handshakes one word and returns in the write cycle.
  task automatic send(input vec_t v, input logic [ADDR_W-1:0] exp_addr, input string name);
    int n = 0;
    while (!in_ready && n < 8) begin
      tick;
      n++;
    end
    chk({name, "_rdy"}, in_ready, 1);
    drive(v);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    chk({name, "_we"}, imem_we, v.legal);
    if (v.legal) begin
      chk({name, "_addr"}, imem_addr, exp_addr);
      chk({name, "_wdata"}, imem_wdata, v.word);
    end
  endtask

  vec_t tbl[15];
  vec_t v_addi, v_r, v_b, v_ret, v_ill;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w0;
    rst_n = 1'b0; load_start = 0; load_done = 0; in_valid = 0;
    op = 0; rs = 0; rt = 0; shamt = 0; func = 0; imm16 = 0; addr26 = 0;

    v_addi = mk(6'b000100, 5'd3, 5'd5, 5'd0, 6'h00, 16'h0010, 26'h0, 32'h10650010, 1'b1);
    v_r    = mk(6'b000000, 5'd1, 5'd2, 5'd0, 6'h01, 16'hFFFF, 26'h3FFFFFF, 32'h00220001, 1'b1);
    v_b    = mk(6'b010000, 5'd7, 5'd9, 5'd3, 6'h3F, 16'h1234, 26'h40, 32'h40000040, 1'b1);
    v_ret  = mk(6'b000111, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h123, 32'h1C000000, 1'b1);
    v_ill  = mk(6'b111111, 5'd1, 5'd1, 5'd1, 6'h01, 16'h0001, 26'h1, 32'h0, 1'b0);

    tbl[0]  = v_addi;
    tbl[1]  = v_r;
    tbl[2]  = v_b;
    tbl[3]  = v_ret;
    tbl[4]  = mk(6'b000000, 5'd31, 5'd0, 5'd5, 6'h20, 16'h0, 26'h0, 32'h03E00160, 1'b1);
    tbl[5]  = mk(6'b000010, 5'd2, 5'd4, 5'd7, 6'h03, 16'h8000, 26'h0, 32'h08448000, 1'b1);
    tbl[6]  = mk(6'b010001, 5'd6, 5'd3, 5'd2, 6'h05, 16'h1234, 26'h3FF, 32'h44C00000, 1'b1);
    tbl[7]  = mk(6'b000110, 5'd1, 5'd0, 5'd0, 6'h00, 16'h0, 26'h2ABCDEF, 32'h1AABCDEF, 1'b1);
    tbl[8]  = mk(6'b011001, 5'd4, 5'd4, 5'd4, 6'h04, 16'h4444, 26'h3FFFFFF, 32'h67FFFFFF, 1'b1);
    tbl[9]  = v_ill;
    tbl[10] = mk(6'b000001, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h0, 32'h0, 1'b0);
    tbl[11] = mk(6'b000011, 5'd0, 5'd31, 5'd0, 6'h00, 16'hFFFF, 26'h0, 32'h0C1FFFFF, 1'b1);
    tbl[12] = mk(6'b000101, 5'd10, 5'd11, 5'd0, 6'h00, 16'h00AB, 26'h0, 32'h154B00AB, 1'b1);
    tbl[13] = mk(6'b010010, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h1, 32'h48000001, 1'b1);
    tbl[14] = mk(6'b011010, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h1, 32'h0, 1'b0);

    #2;
    chk("reset_outs", {in_ready, imem_we, imem_addr, imem_wdata, cpu_start, count, full, err}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick;
    load_done = 1'b1;
    tick;
    load_done = 1'b0;
    chk("idle_done_ignored", {cpu_start, in_ready}, 0);

    for (int i = 0; i < 15; i++) begin
      session;
      send(tbl[i], 0, $sformatf("vec%0d", i));
      tick;
      chk($sformatf("vec%0d_err", i), err, !tbl[i].legal);
      chk($sformatf("vec%0d_count", i), count, tbl[i].legal ? 1 : 0);
    end

    // Single addi then load_done from LOAD: cpu_start two cycles after the write.
    session;
    send(v_addi, 0, "seqA");
    tick;
    chk("seqA_count", count, 1);
    load_done = 1'b1;
    tick;
    load_done = 1'b0;
    chk("seqA_run", {cpu_start, in_ready}, 2'b10);

    // Consecutive addresses across formats.
    session;
    send(v_r, 0, "seqB0");
    send(v_b, 1, "seqB1");
    send(v_ret, 2, "seqB2");
    tick;
    chk("seqB_count", count, 3);

    // Illegal word in the middle: no strobe, sticky err, no address consumed.
    session;
    send(v_addi, 0, "seqC0");
    send(v_ill, 0, "seqC1");
    send(v_r, 1, "seqC2");
    tick;
    chk("seqC_err", err, 1);
    chk("seqC_count", count, 2);

    // load_start beats a coincident handshake and clears the session.
    drive(v_addi);
    in_valid = 1'b1;
    load_start = 1'b1;
    tick;
    in_valid = 1'b0;
    load_start = 1'b0;
    chk("prio_start", {imem_we, in_ready, count, err}, {1'b0, 1'b1, 9'd0, 1'b0});

    // Fill all four slots, then further valid data is refused.
    session;
    send(v_addi, 0, "seqD0");
    send(v_r, 1, "seqD1");
    send(v_b, 2, "seqD2");
    send(v_ret, 3, "seqD3");
    tick;
    chk("seqD_full", {full, in_ready, count}, {1'b1, 1'b0, 9'd4});
    w0 = we_cnt;
    drive(v_addi);
    in_valid = 1'b1;
    repeat (3) tick;
    in_valid = 1'b0;
    chk("seqD_nowrite", we_cnt - w0, 0);
    chk("seqD_count_held", count, 4);
    load_done = 1'b1;
    tick;
    load_done = 1'b0;
    chk("seqD_run", cpu_start, 1);

    // load_done together with the handshake: word written, then RUN.
    session;
    send(v_ill, 0, "seqE0");
    tick;
    drive(v_addi);
    in_valid = 1'b1;
    load_done = 1'b1;
    tick;
    in_valid = 1'b0;
    load_done = 1'b0;
    chk("seqE_write", {imem_we, imem_addr, imem_wdata}, {1'b1, 8'd0, 32'h10650010});
    tick;
    chk("seqE_run", {cpu_start, count}, {1'b1, 9'd1});
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    chk("seqE_restart", {cpu_start, count, err, in_ready}, {1'b0, 9'd0, 1'b0, 1'b1});

    // load_done arriving during WRITE goes straight to RUN after the write.
    send(v_r, 0, "seqF");
    load_done = 1'b1;
    tick;
    load_done = 1'b0;
    chk("seqF_run", {cpu_start, count}, {1'b1, 9'd1});

    // Reset asserted in WRITE kills the strobe before memory samples it.
    session;
    drive(v_addi);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    chk("seqG_pre_we", imem_we, 1);
    w0 = we_cnt;
    rst_n = 1'b0;
    #1;
    chk("seqG_async", {in_ready, imem_we, imem_addr, imem_wdata, cpu_start, count, full, err}, 0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("seqG_nowe", we_cnt - w0, 0);
    chk("seqG_idle", {in_ready, imem_we, cpu_start, count, err}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
